sram_fb_arbiter: RTL and testbench
==================================

SRAM_FB_ARBITER -- requirements
Module: sram_fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 18, meaning SRAM word-address width.
REQ-002 SHALL have parameter DW, default 16, meaning SRAM data width.
REQ-003 SHALL have parameter RD_MAX_CONSEC, default 4, meaning maximum consecutive read grants while a write waits.
REQ-004 SHALL have port sys_clk  input  1  single clock for all logic.
REQ-005 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports rd_req  input  1; rd_addr  input  AW; rd_ready  output  1, meaning read accepted this cycle.
REQ-007 SHALL have ports rd_rvalid  output  1; rd_rdata  output  DW, meaning read data return.
REQ-008 SHALL have ports wr_req  input  1; wr_addr  input  AW; wr_data  input  DW; wr_be  input  2 (active-high byte enables); wr_ready  output  1.
REQ-009 SHALL have ports sram_addr  output  AW; sram_dq  inout  DW; sram_ce_n, sram_oe_n, sram_we_n  output  1 each; sram_be_n  output  2 ({UB,LB}).

Function
REQ-010 SHALL implement an FSM with states IDLE, RD_A, RD_B, WR_A, WR_B; each access SHALL occupy exactly 2 cycles (A then B).
REQ-011 SHALL make a grant decision only in IDLE, RD_B or WR_B; rd_ready/wr_ready SHALL be high only in those states, and never both in the same cycle.
REQ-012 SHALL grant read over write, except when wr_req is high and the consecutive-read counter equals RD_MAX_CONSEC, in which case write SHALL be granted.
REQ-013 SHALL clear the consecutive-read counter on every write grant and on any decision cycle with wr_req low; it SHALL increment on each read grant while wr_req is high and saturate at RD_MAX_CONSEC.
REQ-014 SHALL transition from a decision state to RD_A on a read grant, to WR_A on a write grant, and to IDLE with no request; RD_A->RD_B and WR_A->WR_B SHALL be unconditional.
REQ-015 SHALL register the granted address, data and byte enables in the grant cycle and drive them on the SRAM pins for both the A and B cycles.
REQ-016 Read: SHALL drive ce_n=0, oe_n=0, we_n=1, be_n=2'b00 and sram_dq high-Z during RD_A and RD_B, and SHALL sample sram_dq at the end of RD_B.
REQ-017 Read latency: with rd_req&rd_ready in cycle T, rd_rvalid SHALL pulse high for exactly one cycle at T+3, with rd_rdata valid in that cycle; rd_rdata SHALL hold until the next rvalid.
REQ-018 Write: SHALL drive ce_n=0, oe_n=1 and be_n=~wr_be during WR_A and WR_B; we_n SHALL be 0 in WR_A only; sram_dq SHALL be driven with the data in WR_A and WR_B (hold after we_n rises).
REQ-019 In IDLE SHALL drive ce_n=oe_n=we_n=1, be_n=2'b11 and sram_dq high-Z; sram_addr SHALL retain its last value.
REQ-020 All SRAM control/address outputs SHALL come from registers (no combinational paths to pins).
REQ-021 Sustained throughput SHALL be one access per 2 cycles with back-to-back grants from RD_B/WR_B.
REQ-022 SHALL ignore wr_be=2'b00 writes functionally (cycle still consumed, we_n still pulses, both bytes masked).

Reset
REQ-023 On sys_rst assertion, mid-operation included, SHALL immediately enter IDLE, clear counter, and set sram_addr=0, ce_n=oe_n=we_n=1, be_n=2'b11, dq high-Z, rd_ready=wr_ready=0 while asserted, rd_rvalid=0, rd_rdata=0; an in-flight access SHALL be dropped with no rvalid.

Structure
REQ-024 SHALL place the FSM state enum and the AW/DW default constants in shared package sram_fb_pkg.
REQ-025 SHALL isolate pin registers and the tristate driver in one sub-module sram_fb_phy; arbitration and FSM stay in the top.

Verification
REQ-026 Single read: rd_req@T, addr 0x00010, SRAM model holds 0xBEEF -> oe_n low T+1..T+2, rd_rvalid=1 with 0xBEEF at T+3 only.
REQ-027 Single write: wr addr 0x3FFFF, data 0x1234, be 2'b01 -> we_n low one cycle, be_n=2'b10, model low byte=0x34, high byte unchanged.
REQ-028 Starvation: rd_req and wr_req held high -> grant pattern R,R,R,R,W repeating with RD_MAX_CONSEC=4.
REQ-029 Back-to-back reads at 0,1,2 -> rd_ready every 2nd cycle, three rvalid pulses 2 cycles apart in order.
REQ-030 Reset asserted in WR_A -> we_n=1, dq high-Z same cycle, FSM IDLE; after release, a fresh read returns correct data.
REQ-031 Bus check: no cycle with sram_dq driven while oe_n=0, and never we_n=0 with oe_n=0 (assertion).

Source files
------------

// File: rtl/sram_fb_pkg.sv
// Shared types and default widths for the SRAM read/write arbiter slice.
package sram_fb_pkg;

    localparam int unsigned AW_DEF = 18;
    localparam int unsigned DW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_A,
        WR_B
    } state_t;

    // A new grant may only be issued from these states.
    function automatic logic is_decision(state_t s);
        return (s == IDLE) || (s == RD_B) || (s == WR_B);
    endfunction

endpackage

// File: rtl/sram_fb_phy.sv
// SRAM pin registers and data-bus tristate; pins are decoded from the FSM's next state.
module sram_fb_phy
    import sram_fb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  state_t        nxt,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [1:0]    ld_be,
    input  logic          cap_en,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [1:0]    sram_be_n
);

    logic          dq_oe;
    logic [DW-1:0] dq_out;

    assign sram_dq = dq_oe ? dq_out : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            rdata     <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
        end else begin
            if (ld_en) begin
                sram_addr <= ld_addr;
                dq_out    <= ld_data;
            end
            if (cap_en) begin
                rdata <= sram_dq;
            end
            // Pins for the upcoming cycle, so every SRAM output leaves a flop.
            case (nxt)
                RD_A, RD_B: begin
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b0;
                    sram_we_n <= 1'b1;
                    sram_be_n <= '0;
                    dq_oe     <= 1'b0;
                end
                WR_A: begin
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b0;
                    sram_be_n <= ~ld_be;
                    dq_oe     <= 1'b1;
                end
                WR_B: begin
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_be_n <= sram_be_n;
                    dq_oe     <= 1'b1;
                end
                default: begin
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_be_n <= '1;
                    dq_oe     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_fb_arbiter.sv
// Read-priority SRAM arbiter with bounded write starvation; two-cycle accesses.
module sram_fb_arbiter
    import sram_fb_pkg::*;
#(
    parameter int unsigned AW            = AW_DEF,
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned RD_MAX_CONSEC = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_rvalid,
    output logic [DW-1:0] rd_rdata,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    wr_be,
    output logic          wr_ready,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [1:0]    sram_be_n
);

    localparam int unsigned CW = (RD_MAX_CONSEC > 0) ? $clog2(RD_MAX_CONSEC + 1) : 1;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] rd_cnt;
    logic          decide;
    logic          cnt_max;
    logic          grant_rd;
    logic          grant_wr;

    assign decide   = is_decision(state);
    assign cnt_max  = (rd_cnt == CW'(RD_MAX_CONSEC));
    assign grant_wr = decide & wr_req & (~rd_req | cnt_max);
    assign grant_rd = decide & rd_req & ~(wr_req & cnt_max);
    assign rd_ready = grant_rd & ~sys_rst;
    assign wr_ready = grant_wr & ~sys_rst;

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, RD_B, WR_B: begin
                if (grant_rd) begin
                    next_state = RD_A;
                end else if (grant_wr) begin
                    next_state = WR_A;
                end else begin
                    next_state = IDLE;
                end
            end
            RD_A:    next_state = RD_B;
            WR_A:    next_state = WR_B;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            rd_rvalid <= 1'b0;
        end else begin
            state     <= next_state;
            rd_rvalid <= (state == RD_B);
            if (decide) begin
                if (!wr_req || grant_wr) begin
                    rd_cnt <= '0;
                end else if (grant_rd && !cnt_max) begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
            end
        end
    end

    sram_fb_phy #(
        .AW(AW),
        .DW(DW)
    ) u_phy (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .nxt       (next_state),
        .ld_en     (grant_rd | grant_wr),
        .ld_addr   (grant_wr ? wr_addr : rd_addr),
        .ld_data   (wr_data),
        .ld_be     (wr_be),
        .cap_en    (state == RD_B),
        .rdata     (rd_rdata),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n)
    );

endmodule

// File: tb/tb_sram_fb_arbiter.sv
// Directed self-checking bench for sram_fb_arbiter with a simple async SRAM model.
module tb_sram_fb_arbiter;
    import sram_fb_pkg::*;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be = 2'b00;
    logic          wr_ready;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [1:0]    sram_be_n;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 sys_clk = ~sys_clk;

    sram_fb_arbiter #(
        .AW(AW),
        .DW(DW),
        .RD_MAX_CONSEC(4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_ready  (wr_ready),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n)
    );

    // SRAM model: drives on read enable, latches bytes at clock edges while we_n is low.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge sys_clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!sram_be_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            checks++;
            if (dut.u_phy.dq_oe && !sram_oe_n) begin
                errors++;
                $display("FAIL bus_contention: dq driven while oe_n=%b", sram_oe_n);
            end
        end
    end

    a_we_oe: assert property (@(posedge sys_clk) disable iff (sys_rst) !(!sram_we_n && !sram_oe_n))
        else $error("FAIL bus_we_oe: we_n and oe_n both low");

    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        rd_req = 1'b1;
        #1;
        checks++;
        if (rd_ready !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got rd=%b wr=%b expected 0 0", rd_ready, wr_ready);
        end
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
        end
        checks++;
        if (sram_addr !== 18'h0 || rd_rvalid !== 1'b0 || rd_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h rvalid=%b rdata=%h expected 0 0 0", sram_addr, rd_rvalid, rd_rdata);
        end
        rd_req = 1'b0;
        sys_rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        mem[18'h00010] = 16'hBEEF;
        rd_req = 1'b1;
        rd_addr = 18'h00010;
        #1;
        checks++;
        if (rd_ready !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant: got rd=%b wr=%b expected 1 0", rd_ready, wr_ready);
        end
        cyc();
        rd_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (sram_oe_n !== ((k <= 2) ? 1'b0 : 1'b1) || sram_ce_n !== ((k <= 2) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL rd_oe_t%0d: got oe_n=%b ce_n=%b", k, sram_oe_n, sram_ce_n);
            end
            checks++;
            if (rd_rvalid !== (k == 3)) begin
                errors++;
                $display("FAIL rd_rvalid_t%0d: got %b expected %b", k, rd_rvalid, (k == 3));
            end
            if (k >= 3) begin
                checks++;
                if (rd_rdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL rd_rdata_t%0d: got %h expected beef", k, rd_rdata);
                end
            end
            cyc();
        end
    endtask

    task automatic test_single_write();
        mem[18'h3FFFF] = 16'hABCD;
        wr_req = 1'b1;
        wr_addr = 18'h3FFFF;
        wr_data = 16'h1234;
        wr_be = 2'b01;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant: got wr=%b rd=%b expected 1 0", wr_ready, rd_ready);
        end
        cyc();
        wr_req = 1'b0;
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b01010 || sram_addr !== 18'h3FFFF) begin
            errors++;
            $display("FAIL wr_phase_a: got ctrl=%b addr=%h expected 01010 3ffff", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}, sram_addr);
        end
        cyc();
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b01110) begin
            errors++;
            $display("FAIL wr_phase_b: got %b expected 01110", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n});
        end
        cyc();
        #1;
        checks++;
        if ({sram_ce_n, sram_be_n} !== 3'b111 || sram_addr !== 18'h3FFFF) begin
            errors++;
            $display("FAIL wr_idle: got ce_n/be_n=%b addr=%h expected 111 3ffff", {sram_ce_n, sram_be_n}, sram_addr);
        end
        checks++;
        if (mem[18'h3FFFF] !== 16'hAB34) begin
            errors++;
            $display("FAIL wr_mem: got %h expected ab34", mem[18'h3FFFF]);
        end
        cyc();
    endtask

    task automatic test_zero_be();
        mem[18'h7] = 16'h1357;
        wr_req = 1'b1;
        wr_addr = 18'h7;
        wr_data = 16'hFFFF;
        wr_be = 2'b00;
        cyc();
        wr_req = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b0 || sram_be_n !== 2'b11) begin
            errors++;
            $display("FAIL zbe_pulse: got we_n=%b be_n=%b expected 0 11", sram_we_n, sram_be_n);
        end
        cyc();
        cyc();
        checks++;
        if (mem[18'h7] !== 16'h1357) begin
            errors++;
            $display("FAIL zbe_mem: got %h expected 1357", mem[18'h7]);
        end
    endtask

    task automatic test_starvation();
        logic exp_w;
        rd_req = 1'b1;
        wr_req = 1'b1;
        rd_addr = 18'h20;
        wr_addr = 18'h21;
        wr_data = 16'h0F0F;
        wr_be = 2'b11;
        for (int g = 0; g < 10; g++) begin
            exp_w = ((g % 5) == 4);
            #1;
            checks++;
            if (rd_ready !== ~exp_w || wr_ready !== exp_w) begin
                errors++;
                $display("FAIL starve_g%0d: got rd=%b wr=%b expected rd=%b wr=%b", g, rd_ready, wr_ready, ~exp_w, exp_w);
            end
            cyc();
            cyc();
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [3];
        logic          exp_rdy;
        logic          exp_v;
        exp_d[0] = 16'h1110;
        exp_d[1] = 16'h2221;
        exp_d[2] = 16'h3332;
        for (int i = 0; i < 3; i++) mem[i] = exp_d[i];
        for (int k = 0; k <= 8; k++) begin
            rd_req = (k < 6);
            rd_addr = AW'(k / 2);
            exp_rdy = ((k % 2) == 0) && (k < 6);
            exp_v = (k == 3) || (k == 5) || (k == 7);
            #1;
            checks++;
            if (rd_ready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_ready_k%0d: got %b expected %b", k, rd_ready, exp_rdy);
            end
            checks++;
            if (rd_rvalid !== exp_v) begin
                errors++;
                $display("FAIL b2b_rvalid_k%0d: got %b expected %b", k, rd_rvalid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rd_rdata !== exp_d[(k - 3) / 2]) begin
                    errors++;
                    $display("FAIL b2b_rdata_k%0d: got %h expected %h", k, rd_rdata, exp_d[(k - 3) / 2]);
                end
            end
            cyc();
        end
    endtask

    task automatic test_reset_in_write();
        mem[18'h5] = 16'h0A0A;
        wr_req = 1'b1;
        wr_addr = 18'h5;
        wr_data = 16'h5555;
        wr_be = 2'b11;
        cyc();
        wr_req = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL rstw_in_wra: got we_n=%b expected 0", sram_we_n);
        end
        sys_rst = 1'b1;
        rd_req = 1'b1;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || dut.u_phy.dq_oe !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL rstw_immediate: got we_n=%b ce_n=%b dq_oe=%b state=%0d expected 1 1 0 0",
                     sram_we_n, sram_ce_n, dut.u_phy.dq_oe, dut.state);
        end
        checks++;
        if (rd_ready !== 1'b0 || sram_addr !== 18'h0) begin
            errors++;
            $display("FAIL rstw_ready: got rd_ready=%b addr=%h expected 0 0", rd_ready, sram_addr);
        end
        cyc();
        rd_req = 1'b0;
        sys_rst = 1'b0;
        cyc();
        cyc();
        checks++;
        if (rd_rvalid !== 1'b0 || mem[18'h5] !== 16'h0A0A) begin
            errors++;
            $display("FAIL rstw_dropped: got rvalid=%b mem=%h expected 0 0a0a", rd_rvalid, mem[18'h5]);
        end
        rd_req = 1'b1;
        rd_addr = 18'h00010;
        cyc();
        rd_req = 1'b0;
        cyc();
        cyc();
        #1;
        checks++;
        if (rd_rvalid !== 1'b1 || rd_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rstw_fresh_read: got rvalid=%b rdata=%h expected 1 beef", rd_rvalid, rd_rdata);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_zero_be();
        test_starvation();
        test_back_to_back();
        test_reset_in_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
